// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter that drives a 3-to-8 decoder's E/In so that its output is the one-hot grant.
// The hold time is bounded so that a requester cannot keep the grant while others are waiting.
module decoder_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clka,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic       dec_E,
  output logic [2:0] dec_In,
  output logic       busy,
  output logic       rel,
  output logic [3:0] hold_cnt
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  localparam logic [3:0] MaxHold = 4'(MAX_HOLD);

  state_e     state_q, state_d;
  logic [2:0] dec_in_q, dec_in_d;
  logic [2:0] ptr_q, ptr_d;
  logic [3:0] hold_q, hold_d;
  logic       rel_q, rel_d;

  logic [7:0] others;
  logic [3:0] pick_idle;
  logic [3:0] pick_rel;
  logic       release_c;

  // Returns {found, index} of the first set bit scanning p+1, p+2, ... modulo 8.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic       found;
    logic [2:0] idx;
    logic [2:0] k;
    found = 1'b0;
    idx   = 3'd0;
    for (int i = 1; i <= 8; i++) begin
      k = p + 3'(i);
      if (!found && r[k]) begin
        found = 1'b1;
        idx   = k;
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    others    = req & ~(8'b1 << dec_in_q);
    pick_idle = rr_pick(req, ptr_q);
    pick_rel  = rr_pick(others, dec_in_q);
    release_c = !en || !req[dec_in_q] || ((hold_q == MaxHold) && (|others));
  end

  always_comb begin
    state_d  = state_q;
    dec_in_d = dec_in_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    rel_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en && pick_idle[3]) begin
          state_d  = StGrant;
          dec_in_d = pick_idle[2:0];
          ptr_d    = pick_idle[2:0];
          hold_d   = 4'd1;
        end
      end
      StGrant: begin
        if (!release_c) begin
          hold_d = (hold_q >= MaxHold) ? MaxHold : hold_q + 4'd1;
        end else begin
          rel_d = 1'b1;
          // Hand over without an idle gap when someone else is waiting.
          if (en && pick_rel[3]) begin
            dec_in_d = pick_rel[2:0];
            ptr_d    = pick_rel[2:0];
            hold_d   = 4'd1;
          end else begin
            state_d = StIdle;
            hold_d  = 4'd0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      dec_in_q <= 3'd0;
      ptr_q    <= 3'd7;
      hold_q   <= 4'd0;
      rel_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dec_in_q <= dec_in_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
      rel_q    <= rel_d;
    end
  end

  assign dec_E    = (state_q == StGrant);
  assign busy     = (state_q == StGrant);
  assign dec_In   = dec_in_q;
  assign rel      = rel_q;
  assign hold_cnt = hold_q;

endmodule
